// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-to-1 round-robin valid/ready merge with a registered, channel-tagged output.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module rr_stream_mux #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
`ifdef STREAM_MUX_PKT_LOCK_EN
   input  logic [NUM_CH-1:0]        in_last,
   output logic                     out_last,
`endif
   output logic [NUM_CH-1:0]        in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_sel,
   input  logic                     out_ready
);

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0]  out_sel_q, out_sel_d;

   logic [DATA_W-1:0] ch_data [NUM_CH];
   logic [NUM_CH-1:0] vv_rot;
   logic              rr_vld;
   logic [SEL_W-1:0]  rr_gnt;
   logic              gnt_vld;
   logic [SEL_W-1:0]  gnt;
   logic [SEL_W-1:0]  gnt_inc;
   logic              load_en;
   logic              accept;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
   end

   assign load_en = ~out_valid_q | out_ready;

   // Rotate valids so bit 0 is the pointer channel; lowest set bit wins.
   always_comb begin
      vv_rot = NUM_CH'({in_valid, in_valid} >> ptr_q);
   end

   always_comb begin
      logic [SEL_W:0] sum;
      rr_vld = 1'b0;
      rr_gnt = '0;
      sum    = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (vv_rot[k]) begin
            sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
            if (sum >= (SEL_W+1)'(NUM_CH)) begin
               sum = sum - (SEL_W+1)'(NUM_CH);
            end
            rr_vld = 1'b1;
            rr_gnt = sum[SEL_W-1:0];
         end
      end
   end

`ifdef STREAM_MUX_PKT_LOCK_EN
   typedef enum logic {ARB, LOCKED} lock_e;

   lock_e            lock_q, lock_d;
   logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
   logic             out_last_q, out_last_d;

   always_comb begin
      gnt     = rr_gnt;
      gnt_vld = rr_vld;
      if (lock_q == LOCKED) begin
         gnt     = lock_ch_q;
         gnt_vld = in_valid[lock_ch_q];
      end
   end
`else
   assign gnt     = rr_gnt;
   assign gnt_vld = rr_vld;
`endif

   assign gnt_inc  = (gnt == LAST_CH) ? '0 : gnt + SEL_W'(1);
   assign accept   = gnt_vld & load_en;
   assign in_ready = (rst_n & accept) ? (NUM_CH'(1) << gnt) : '0;

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_d      = lock_q;
      lock_ch_d   = lock_ch_q;
      out_last_d  = out_last_q;
`endif
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = ch_data[gnt];
         out_sel_d   = gnt;
`ifdef STREAM_MUX_PKT_LOCK_EN
         out_last_d  = in_last[gnt];
         if (in_last[gnt]) begin
            lock_d = ARB;
            ptr_d  = gnt_inc;
         end else begin
            lock_d    = LOCKED;
            lock_ch_d = gnt;
         end
`else
         ptr_d       = gnt_inc;
`endif
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
         lock_q      <= ARB;
         lock_ch_q   <= '0;
         out_last_q  <= 1'b0;
`endif
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
         lock_q      <= lock_d;
         lock_ch_q   <= lock_ch_d;
         out_last_q  <= out_last_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
   assign out_last  = out_last_q;
`endif

endmodule
